ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Pipeline sequencer for the EX stage of the 8-bit accumulator CPU.
- Detects read-after-write hazards on accumulators A/B between the instruction in ID and the instruction leaving EX.
- Stalls IF/ID and injects bubbles into EX until the accumulator write-back completes.
- Squashes wrong-path instructions after a taken branch/JMP. Sits beside the ID/EX pipeline register and drives its hold/clear controls.

Parameters:
WB_LAT, 2, cycles from an instruction leaving EX until its accumulator write is visible to ID (legal 1..7)
FLUSH_CYC, 1, cycles of squash after a taken branch (legal 1..7)
CNT_W, 3, width of the internal stall/flush counter

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
iIdValid  in  1  ID stage holds a valid instruction
iUseAcum_ID  in  2  bit0: ID instruction reads AcumA; bit1: reads AcumB (operand mux selects or branch test source)
iControlAcum_EX  in  3  accumulator-write code of the instruction in EX: 000 noLoad, 001 loadConstantA, 010 loadMemoryA, 011 loadConstantB, 100 loadMemoryB; 101..111 treated as noLoad
iBranchTaken_EX  in  1  EX resolved a taken branch/JMP this cycle
oStall  out  1  hold PC and the IF/ID register
oFlush  out  1  clear the ID/EX register (bubble: controlAcum=000, memEnable=0)
oSquash_ID  out  1  clear the IF/ID register
oState  out  2  current FSM state (debug)

Behaviour:
- Single clock domain, Clock. Reset is synchronous and active-high.
- Reset: state=RUN, counter=0. While Reset is high, oStall, oFlush and oSquash_ID are 0 and oState=00.
- Reset asserted mid-STALL or mid-FLUSH aborts the sequence; RUN on the next edge.
- States: RUN=00, STALL=01, FLUSH=10; 11 is illegal and goes to RUN on the next edge with outputs 0.
- Outputs are Mealy: combinational from state and inputs. Zero-cycle response to a hazard or branch in the same cycle.
- Hazard (evaluated in RUN only) is true when iIdValid=1 and either:
  - iControlAcum_EX is 001 or 010, and iUseAcum_ID[0]=1; or
  - iControlAcum_EX is 011 or 100, and iUseAcum_ID[1]=1.
- RUN, priority 1, iBranchTaken_EX=1 (wins over hazard):
  - oSquash_ID=1, oFlush=1, oStall=0.
  - counter<=FLUSH_CYC-1.
  - Next state FLUSH if FLUSH_CYC>1, else RUN.
- RUN, priority 2, hazard:
  - oStall=1, oFlush=1, oSquash_ID=0.
  - counter<=WB_LAT-1.
  - Next state STALL if WB_LAT>1, else RUN.
- RUN, otherwise: all outputs 0.
- STALL:
  - oStall=1, oFlush=1, oSquash_ID=0. Hazard inputs and iBranchTaken_EX are ignored (EX holds a bubble).
  - If counter==1, next state RUN, else counter decrements.
  - The hazard is re-evaluated in RUN, so back-to-back dependencies re-stall naturally.
- FLUSH:
  - oSquash_ID=1, oFlush=1, oStall=0. iBranchTaken_EX is ignored.
  - If counter==1, next state RUN, else counter decrements.
- Totals: a hazard costs exactly WB_LAT stall cycles; a taken branch costs exactly FLUSH_CYC squash cycles.
- Counter is unsigned CNT_W bits. It never decrements below 1 in STALL/FLUSH and never wraps.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds two ports:
  - oStallCount out 16: counts cycles with oStall=1.
  - oFlushCount out 16: counts cycles with oSquash_ID=1.
  - Both saturate at 16'hFFFF and clear to 0 on Reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles with iBranchTaken_EX=1 and hazard inputs active -> all outputs 0, oState=00. First cycle after release with the same inputs -> oSquash_ID=1 (branch priority).
- WB_LAT=2, iControlAcum_EX=010, iUseAcum_ID=01, iIdValid=1, then iControlAcum_EX=000 -> oStall=oFlush=1 for exactly 2 cycles (RUN→STALL→RUN), then 0.
- iControlAcum_EX=011, iUseAcum_ID=01 (reads A only) -> no stall. iUseAcum_ID=10 -> stall. iIdValid=0 with iUseAcum_ID=10 -> no stall.
- FLUSH_CYC=3, iBranchTaken_EX=1 for one cycle -> oSquash_ID=oFlush=1 for 3 cycles, oStall=0. Hazard input during FLUSH is ignored. Simultaneous branch and hazard in RUN -> flush taken, no stall.
- Reset asserted during the 2nd STALL cycle (WB_LAT=4) -> outputs 0 that cycle, RUN next, no residual stall.
- With HAZ_PERF_CNT_EN: 2 hazards (WB_LAT=2) and 1 branch (FLUSH_CYC=1) -> oStallCount=4, oFlushCount=1. 70000 forced stall cycles -> oStallCount=16'hFFFF.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard/branch sequencer for the 8-bit accumulator CPU: stalls on A/B RAW hazards, squashes after taken branches.
// Optional HAZ_PERF_CNT_EN adds saturating stall/squash cycle counters.
module ex_hazard_ctrl #(
    parameter int WB_LAT    = 2,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iIdValid,
    input  logic [1:0] iUseAcum_ID,
    input  logic [2:0] iControlAcum_EX,
    input  logic       iBranchTaken_EX,
    output logic       oStall,
    output logic       oFlush,
    output logic       oSquash_ID,
`ifdef HAZ_PERF_CNT_EN
    output logic [15:0] oStallCount,
    output logic [15:0] oFlushCount,
`endif
    output logic [1:0] oState
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10,
        ILL   = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_hazard;
    logic               w_writes_a;
    logic               w_writes_b;

    // Codes 101..111 decode as noLoad and never create a hazard.
    assign w_writes_a = (iControlAcum_EX == 3'b001) || (iControlAcum_EX == 3'b010);
    assign w_writes_b = (iControlAcum_EX == 3'b011) || (iControlAcum_EX == 3'b100);
    assign w_hazard   = iIdValid && ((w_writes_a && iUseAcum_ID[0]) ||
                                     (w_writes_b && iUseAcum_ID[1]));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        oStall     = 1'b0;
        oFlush     = 1'b0;
        oSquash_ID = 1'b0;
        case (r_state)
            RUN: begin
                if (iBranchTaken_EX) begin
                    oSquash_ID = 1'b1;
                    oFlush     = 1'b1;
                    w_cnt_nxt  = CNT_W'(FLUSH_CYC - 1);
                    w_next     = (FLUSH_CYC > 1) ? FLUSH : RUN;
                end else if (w_hazard) begin
                    oStall    = 1'b1;
                    oFlush    = 1'b1;
                    w_cnt_nxt = CNT_W'(WB_LAT - 1);
                    w_next    = (WB_LAT > 1) ? STALL : RUN;
                end
            end
            STALL: begin
                oStall = 1'b1;
                oFlush = 1'b1;
                if (r_cnt == CNT_W'(1)) w_next    = RUN;
                else                    w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            FLUSH: begin
                oSquash_ID = 1'b1;
                oFlush     = 1'b1;
                if (r_cnt == CNT_W'(1)) w_next    = RUN;
                else                    w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            default: begin
                w_next    = RUN;
                w_cnt_nxt = '0;
            end
        endcase
        // Reset masks the Mealy outputs in the same cycle it is sampled.
        if (Reset) begin
            oStall     = 1'b0;
            oFlush     = 1'b0;
            oSquash_ID = 1'b0;
        end
    end

    assign oState = Reset ? 2'b00 : r_state;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (oStall && (r_stall_cnt != 16'hFFFF))     r_stall_cnt <= r_stall_cnt + 16'd1;
            if (oSquash_ID && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign oStallCount = r_stall_cnt;
    assign oFlushCount = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: instance 0 uses WB_LAT=2/FLUSH_CYC=3, instance 1 uses WB_LAT=4/FLUSH_CYC=1.
// Expected {stall,flush,squash,state} are queued when driven and checked at the following falling edge.
module tb_ex_hazard_ctrl;

    logic       Clock = 1'b0;
    logic       rst   [2];
    logic       vld   [2];
    logic [1:0] use_a [2];
    logic [2:0] ctl   [2];
    logic       br    [2];
    logic       o_stall  [2];
    logic       o_flush  [2];
    logic       o_squash [2];
    logic [1:0] o_state  [2];
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] o_scnt [2];
    logic [15:0] o_fcnt [2];
`endif

    always #5 Clock = ~Clock;

    ex_hazard_ctrl #(.WB_LAT(2), .FLUSH_CYC(3), .CNT_W(3)) u_a (
        .Clock(Clock), .Reset(rst[0]), .iIdValid(vld[0]), .iUseAcum_ID(use_a[0]),
        .iControlAcum_EX(ctl[0]), .iBranchTaken_EX(br[0]),
        .oStall(o_stall[0]), .oFlush(o_flush[0]), .oSquash_ID(o_squash[0]),
`ifdef HAZ_PERF_CNT_EN
        .oStallCount(o_scnt[0]), .oFlushCount(o_fcnt[0]),
`endif
        .oState(o_state[0])
    );

    ex_hazard_ctrl #(.WB_LAT(4), .FLUSH_CYC(1), .CNT_W(3)) u_b (
        .Clock(Clock), .Reset(rst[1]), .iIdValid(vld[1]), .iUseAcum_ID(use_a[1]),
        .iControlAcum_EX(ctl[1]), .iBranchTaken_EX(br[1]),
        .oStall(o_stall[1]), .oFlush(o_flush[1]), .oSquash_ID(o_squash[1]),
`ifdef HAZ_PERF_CNT_EN
        .oStallCount(o_scnt[1]), .oFlushCount(o_fcnt[1]),
`endif
        .oState(o_state[1])
    );

    typedef struct {
        int         d;
        logic [4:0] v;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic step(input int d, input logic r, input logic v, input logic [1:0] u,
                        input logic [2:0] c, input logic b, input logic [4:0] e, input string tag);
        exp_t   x;
        logic [4:0] obs;
        rst[d] = r; vld[d] = v; use_a[d] = u; ctl[d] = c; br[d] = b;
        x.d = d; x.v = e; x.tag = tag;
        exp_q.push_back(x);
        @(negedge Clock);
        x = exp_q.pop_front();
        obs = {o_stall[x.d], o_flush[x.d], o_squash[x.d], o_state[x.d]};
        n_chk++;
        assert (obs === x.v) else begin
            n_fail++;
            $error("FAIL %s observed={stall,flush,squash,state}=%b expected=%b", x.tag, obs, x.v);
        end
        @(posedge Clock);
        #1;
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] e);
        n_chk++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; vld[i] = 1'b0; use_a[i] = 2'b00; ctl[i] = 3'b000; br[i] = 1'b0;
        end
        #1;
        // Reset with branch and hazard both asserted
        step(0, 1, 1, 2'b11, 3'b010, 1, 5'b00000, "rst_c0");
        step(0, 1, 1, 2'b11, 3'b010, 1, 5'b00000, "rst_c1");
        rst[1] = 1'b0;
        step(0, 1, 1, 2'b11, 3'b010, 1, 5'b00000, "rst_c2");
        step(0, 0, 1, 2'b11, 3'b010, 1, 5'b01100, "br_prio_after_rst");
        step(0, 0, 0, 2'b00, 3'b000, 0, 5'b01110, "flush_c2");
        step(0, 0, 0, 2'b00, 3'b000, 0, 5'b01110, "flush_c3");
        step(0, 0, 0, 2'b00, 3'b000, 0, 5'b00000, "flush_done");
        // Load-A RAW hazard
        step(0, 0, 1, 2'b01, 3'b010, 0, 5'b11000, "hazA_run");
        step(0, 0, 1, 2'b01, 3'b000, 0, 5'b11001, "hazA_stall");
        step(0, 0, 1, 2'b01, 3'b000, 0, 5'b00000, "hazA_done");
        // Operand selectivity and valid gating
        step(0, 0, 1, 2'b01, 3'b011, 0, 5'b00000, "ldB_readsA_nohaz");
        step(0, 0, 1, 2'b10, 3'b011, 0, 5'b11000, "ldB_readsB_haz");
        step(0, 0, 1, 2'b10, 3'b000, 0, 5'b11001, "ldB_stall");
        step(0, 0, 0, 2'b10, 3'b011, 0, 5'b00000, "invalid_nohaz");
        step(0, 0, 1, 2'b11, 3'b101, 0, 5'b00000, "code101_noload");
        // Hazard during flush is ignored, then re-evaluated in RUN
        step(0, 0, 0, 2'b00, 3'b000, 1, 5'b01100, "br_run");
        step(0, 0, 1, 2'b01, 3'b001, 0, 5'b01110, "flush_ign_haz1");
        step(0, 0, 1, 2'b01, 3'b001, 0, 5'b01110, "flush_ign_haz2");
        step(0, 0, 1, 2'b01, 3'b001, 0, 5'b11000, "haz_after_flush");
        step(0, 0, 1, 2'b01, 3'b000, 0, 5'b11001, "haz_after_flush_stall");
        step(0, 0, 0, 2'b00, 3'b000, 0, 5'b00000, "idle");
        // Simultaneous branch and hazard; branch ignored inside FLUSH
        step(0, 0, 1, 2'b11, 3'b100, 1, 5'b01100, "br_and_haz");
        step(0, 0, 0, 2'b00, 3'b000, 1, 5'b01110, "flush_ign_br");
        step(0, 0, 0, 2'b00, 3'b000, 0, 5'b01110, "flush_last");
        step(0, 0, 0, 2'b00, 3'b000, 0, 5'b00000, "flush_exact3");
        // WB_LAT=4: reset aborts in the 2nd stall cycle
        step(1, 0, 1, 2'b01, 3'b001, 0, 5'b11000, "b_haz");
        step(1, 0, 1, 2'b01, 3'b000, 0, 5'b11001, "b_stall1");
        step(1, 1, 1, 2'b01, 3'b000, 0, 5'b00000, "b_rst_mid_stall");
        step(1, 0, 0, 2'b00, 3'b000, 0, 5'b00000, "b_no_residual1");
        step(1, 0, 0, 2'b00, 3'b000, 0, 5'b00000, "b_no_residual2");
        // WB_LAT=4 full length, FLUSH_CYC=1 single-cycle squash
        step(1, 0, 1, 2'b10, 3'b100, 0, 5'b11000, "b_full_haz");
        step(1, 0, 1, 2'b10, 3'b000, 0, 5'b11001, "b_full_s1");
        step(1, 0, 1, 2'b10, 3'b000, 0, 5'b11001, "b_full_s2");
        step(1, 0, 1, 2'b10, 3'b000, 0, 5'b11001, "b_full_s3");
        step(1, 0, 1, 2'b10, 3'b000, 0, 5'b00000, "b_full_done");
        step(1, 0, 0, 2'b00, 3'b000, 1, 5'b01100, "b_br_1cyc");
        step(1, 0, 0, 2'b00, 3'b000, 0, 5'b00000, "b_br_done");
`ifdef HAZ_PERF_CNT_EN
        step(0, 1, 0, 2'b00, 3'b000, 0, 5'b00000, "perf_rst");
        step(0, 0, 1, 2'b01, 3'b010, 0, 5'b11000, "perf_haz1");
        step(0, 0, 1, 2'b01, 3'b000, 0, 5'b11001, "perf_haz1_s");
        step(0, 0, 1, 2'b10, 3'b011, 0, 5'b11000, "perf_haz2");
        step(0, 0, 1, 2'b10, 3'b000, 0, 5'b11001, "perf_haz2_s");
        step(0, 0, 0, 2'b00, 3'b000, 1, 5'b01100, "perf_br");
        step(0, 0, 0, 2'b00, 3'b000, 0, 5'b01110, "perf_br_f2");
        step(0, 0, 0, 2'b00, 3'b000, 0, 5'b01110, "perf_br_f3");
        step(0, 0, 0, 2'b00, 3'b000, 0, 5'b00000, "perf_idle");
        chk16("stall_count", o_scnt[0], 16'd4);
        chk16("flush_count", o_fcnt[0], 16'd3);
        rst[0] = 1'b0; vld[0] = 1'b1; use_a[0] = 2'b01; ctl[0] = 3'b001; br[0] = 1'b0;
        repeat (70000) @(posedge Clock);
        @(negedge Clock);
        chk16("stall_count_sat", o_scnt[0], 16'hFFFF);
        chk16("flush_count_hold", o_fcnt[0], 16'd3);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
